// File: rtl/draw_sprite_pkg.sv
// ============================================================================
// Module      : draw_sprite_pkg
// Description : VGA bus layout and shared constants for the sprite draw stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package draw_sprite_pkg;

    localparam int VGA_HCOUNT_BITS = 11;
    localparam int VGA_VCOUNT_BITS = 11;
    localparam int VGA_RGB_BITS    = 12;

    typedef struct packed {
        logic [VGA_HCOUNT_BITS-1:0] hcount;
        logic [VGA_VCOUNT_BITS-1:0] vcount;
        logic                       hsync;
        logic                       vsync;
        logic                       hblnk;
        logic                       vblnk;
        logic [VGA_RGB_BITS-1:0]    rgb;
    } vga_bus_t;

    localparam int VGA_BUS_SIZE = $bits(vga_bus_t);

    // Visible area of the 1024x768 mode; positions outside it never draw.
    localparam int SCREEN_W = 1024;
    localparam int SCREEN_H = 768;

    // Position arithmetic is done 13 bits wide so box edges never wrap.
    localparam int POS_W = 13;

    function automatic logic [POS_W-1:0] pos_ext(input logic [11:0] value);
        return {1'b0, value};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_delay.sv
// ============================================================================
// Module      : vga_delay
// Description : Reset-to-zero shift register used to align VGA bus data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/draw_sprite.sv
// ============================================================================
// Module      : draw_sprite
// Description : VGA-bus sprite overlay with colour keying and ROM alignment.
//               Optional horizontal flip enabled by defining SPRITE_MIRROR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module draw_sprite
    import draw_sprite_pkg::*;
#(
    parameter int          SPRITE_W    = 64,
    parameter int          SPRITE_H    = 64,
    parameter int          ADDR_W      = 12,
    parameter int          ROM_LATENCY = 1,
    parameter logic [11:0] COLOR_KEY   = 12'hF0F
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic [VGA_BUS_SIZE-1:0] vga_in,
    input  logic [11:0]             xpos,
    input  logic [11:0]             ypos,
    input  logic                    sprite_en,
`ifdef SPRITE_MIRROR_EN
    input  logic                    mirror,
`endif
    input  logic [11:0]             rgb_pixel,
    output logic [ADDR_W-1:0]       pixel_addr,
    output logic [VGA_BUS_SIZE-1:0] vga_out
);

    localparam int c_MUL_W = 24;
    localparam int c_DLY_W = VGA_BUS_SIZE + 1;

    vga_bus_t             w_bus_in;
    logic [11:0]          r_xpos;
    logic [11:0]          r_ypos;
    logic                 r_en;
    logic                 r_vblnk_prev;
    logic                 w_vblnk_rise;

    logic [POS_W-1:0]     w_h;
    logic [POS_W-1:0]     w_v;
    logic [POS_W-1:0]     w_x;
    logic [POS_W-1:0]     w_y;
    logic [POS_W-1:0]     w_col_raw;
    logic [POS_W-1:0]     w_col;
    logic [POS_W-1:0]     w_row;
    logic                 w_on_screen;
    logic                 w_in_box;
    logic [ADDR_W-1:0]    w_addr;

    logic                 r_in_box;
    vga_bus_t             r_bus1;
    logic [c_DLY_W-1:0]   w_dly_in;
    logic [c_DLY_W-1:0]   w_dly_out;
    logic                 w_in_box_d;
    vga_bus_t             w_bus_d;
    vga_bus_t             r_out;

    assign w_bus_in     = vga_in;
    assign w_vblnk_rise = w_bus_in.vblnk & ~r_vblnk_prev;

    // The edge detector resets high so a reset released inside vblank is not
    // mistaken for a fresh vblank rise.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_xpos       <= '0;
            r_ypos       <= '0;
            r_en         <= 1'b0;
            r_vblnk_prev <= 1'b1;
        end else begin
            r_vblnk_prev <= w_bus_in.vblnk;
            if (w_vblnk_rise) begin
                r_xpos <= xpos;
                r_ypos <= ypos;
                r_en   <= sprite_en;
            end
        end
    end

    assign w_h = {2'b00, w_bus_in.hcount};
    assign w_v = {2'b00, w_bus_in.vcount};
    assign w_x = pos_ext(r_xpos);
    assign w_y = pos_ext(r_ypos);

    assign w_on_screen = (r_xpos < 12'(SCREEN_W)) && (r_ypos < 12'(SCREEN_H));

    assign w_in_box = r_en && w_on_screen && !w_bus_in.hblnk && !w_bus_in.vblnk
                   && (w_h >= w_x) && (w_h < w_x + POS_W'(SPRITE_W))
                   && (w_v >= w_y) && (w_v < w_y + POS_W'(SPRITE_H));

    assign w_col_raw = w_h - w_x;
    assign w_row     = w_v - w_y;

`ifdef SPRITE_MIRROR_EN
    logic r_mirror;

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_mirror <= 1'b0;
        end else if (w_vblnk_rise) begin
            r_mirror <= mirror;
        end
    end

    assign w_col = r_mirror ? (POS_W'(SPRITE_W - 1) - w_col_raw) : w_col_raw;
`else
    assign w_col = w_col_raw;
`endif

    assign w_addr = ADDR_W'(c_MUL_W'(w_row) * c_MUL_W'(SPRITE_W) + c_MUL_W'(w_col));

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_in_box   <= 1'b0;
            r_bus1     <= '0;
            pixel_addr <= '0;
        end else begin
            r_in_box <= w_in_box;
            r_bus1   <= w_bus_in;
            if (w_in_box) begin
                pixel_addr <= w_addr;
            end
        end
    end

    // Hold the bus and hit flag until the ROM data for this pixel arrives.
    assign w_dly_in = {r_in_box, r_bus1};

    vga_delay #(
        .WIDTH (c_DLY_W),
        .DEPTH (ROM_LATENCY)
    ) u_align (
        .clk    (pclk),
        .rst    (rst),
        .i_data (w_dly_in),
        .o_data (w_dly_out)
    );

    assign w_in_box_d = w_dly_out[c_DLY_W-1];
    assign w_bus_d    = w_dly_out[VGA_BUS_SIZE-1:0];

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_bus_d;
            if (w_in_box_d && (rgb_pixel != COLOR_KEY)) begin
                r_out.rgb <= rgb_pixel;
            end
        end
    end

    assign vga_out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_draw_sprite.sv
// ============================================================================
// Module      : tb_draw_sprite
// Description : Directed plus randomized bench for draw_sprite against a
//               pixel-level reference model and a behavioural sprite ROM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_draw_sprite;
    import draw_sprite_pkg::*;

    localparam int          W   = 64;
    localparam int          H   = 64;
    localparam int          AW  = 12;
    localparam logic [11:0] KEY = 12'hF0F;

    logic                    pclk = 1'b0;
    logic                    rst;
    vga_bus_t                bus_w;
    logic [11:0]             xpos_i;
    logic [11:0]             ypos_i;
    logic                    en_i;
`ifdef SPRITE_MIRROR_EN
    logic                    mirror_i;
`endif
    logic [11:0]             rgb_pixel = '0;
    logic [AW-1:0]           pixel_addr;
    logic [VGA_BUS_SIZE-1:0] vga_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int       lx, ly;
    bit       len, lm, prev;
    int       exp_addr;
    vga_bus_t exp_q[$];

    always #5 pclk = ~pclk;

    draw_sprite #(
        .SPRITE_W    (W),
        .SPRITE_H    (H),
        .ADDR_W      (AW),
        .ROM_LATENCY (1),
        .COLOR_KEY   (KEY)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .vga_in     (bus_w),
        .xpos       (xpos_i),
        .ypos       (ypos_i),
        .sprite_en  (en_i),
`ifdef SPRITE_MIRROR_EN
        .mirror     (mirror_i),
`endif
        .rgb_pixel  (rgb_pixel),
        .pixel_addr (pixel_addr),
        .vga_out    (vga_out)
    );

    function automatic logic [11:0] rom_fn(input int a);
        return (a == 5) ? 12'hF0F : 12'(a);
    endfunction

    always @(posedge pclk) rgb_pixel <= rom_fn(int'(pixel_addr));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        lx = 0; ly = 0; len = 0; lm = 0; prev = 1; exp_addr = 0;
        exp_q = {};
        for (int i = 0; i < 3; i++) exp_q.push_back('0);
    endtask

    task automatic model_step();
        vga_bus_t e;
        int h, v, col;
        logic [11:0] romv;
        if (rst) begin
            model_reset();
        end else begin
            e = bus_w;
            h = int'(bus_w.hcount);
            v = int'(bus_w.vcount);
            if (len && !bus_w.hblnk && !bus_w.vblnk && lx < SCREEN_W && ly < SCREEN_H
                && h >= lx && h < lx + W && v >= ly && v < ly + H) begin
                col = lm ? (W - 1 - (h - lx)) : (h - lx);
                exp_addr = ((v - ly) * W + col) % (1 << AW);
                romv = rom_fn(exp_addr);
                if (romv != KEY) e.rgb = romv;
            end
            exp_q.push_back(e);
            void'(exp_q.pop_front());
            if (bus_w.vblnk && !prev) begin
                lx = int'(xpos_i); ly = int'(ypos_i); len = en_i;
`ifdef SPRITE_MIRROR_EN
                lm = mirror_i;
`else
                lm = 0;
`endif
            end
            prev = bus_w.vblnk;
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
        model_step();
        check("vga_out", 64'(vga_out), 64'(exp_q[0]));
        check("pixel_addr", 64'(pixel_addr), 64'(exp_addr));
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb);
        bus_w.hcount = 11'(h);
        bus_w.vcount = 11'(v);
        bus_w.hsync  = 1'($urandom_range(0, 1));
        bus_w.vsync  = 1'($urandom_range(0, 1));
        bus_w.hblnk  = hb;
        bus_w.vblnk  = vb;
        bus_w.rgb    = 12'($urandom);
        step();
    endtask

    task automatic scan_row(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) begin
            if (h >= 0 && h < SCREEN_W) drive(h, v, 1'b0, 1'b0);
        end
    endtask

    task automatic vblank_pulse();
        drive(1030, 767, 1'b1, 1'b0);
        drive(0, 768, 1'b1, 1'b1);
        drive(1, 768, 1'b1, 1'b1);
        drive(0, 0, 1'b1, 1'b0);
    endtask

    task automatic set_pos(input int x, input int y, input logic en, input logic mir);
        xpos_i = 12'(x);
        ypos_i = 12'(y);
        en_i   = en;
`ifdef SPRITE_MIRROR_EN
        mirror_i = mir;
`else
        if (mir) xpos_i = 12'(x);
`endif
    endtask

    initial begin
        int bx, by, v, hs;
        rst = 1'b1;
        bus_w = '0;
        set_pos(0, 0, 1'b0, 1'b0);
        model_reset();
        repeat (3) step();
        check("reset_vga_out", 64'(vga_out), 64'd0);
        check("reset_addr", 64'(pixel_addr), 64'd0);
        rst = 1'b0;

        // Enable presented before any vblank rise: nothing drawn yet
        set_pos(100, 200, 1'b1, 1'b0);
        scan_row(200, 96, 110);

        vblank_pulse();
        scan_row(200, 96, 99);
        drive(100, 200, 1'b0, 1'b0);
        check("addr_origin", 64'(pixel_addr), 64'd0);
        scan_row(200, 101, 170);
        scan_row(263, 158, 162);
        drive(163, 263, 1'b0, 1'b0);
        check("addr_last", 64'(pixel_addr), 64'd4095);
        scan_row(264, 98, 102);

        // Mid-frame move takes effect only at the next vblank rise
        set_pos(300, 200, 1'b1, 1'b0);
        scan_row(201, 96, 104);
        scan_row(201, 296, 304);
        vblank_pulse();
        scan_row(201, 96, 104);
        scan_row(201, 296, 304);

        // Right-edge clipping
        set_pos(1000, 0, 1'b1, 1'b0);
        vblank_pulse();
        scan_row(0, 0, 45);
        scan_row(0, 995, 1022);
        drive(1023, 0, 1'b0, 1'b0);
        check("addr_clip", 64'(pixel_addr), 64'd23);

        // Off-screen positions and top-left corner
        set_pos(1100, 10, 1'b1, 1'b0);
        vblank_pulse();
        scan_row(10, 0, 70);
        set_pos(10, 800, 1'b1, 1'b0);
        vblank_pulse();
        scan_row(0, 5, 20);
        set_pos(0, 0, 1'b1, 1'b0);
        vblank_pulse();
        scan_row(0, 0, 66);
        scan_row(63, 60, 66);

        // Reset mid-line, then reset coinciding with a vblank rise
        set_pos(100, 200, 1'b1, 1'b0);
        vblank_pulse();
        scan_row(200, 98, 110);
        rst = 1'b1;
        drive(111, 200, 1'b0, 1'b0);
        drive(112, 200, 1'b0, 1'b0);
        check("rst_out_zero", 64'(vga_out), 64'd0);
        rst = 1'b0;
        scan_row(200, 113, 130);
        rst = 1'b1;
        drive(1030, 767, 1'b1, 1'b0);
        drive(0, 768, 1'b1, 1'b1);
        rst = 1'b0;
        drive(1, 768, 1'b1, 1'b1);
        drive(0, 0, 1'b1, 1'b0);
        scan_row(200, 98, 110);
        vblank_pulse();
        scan_row(200, 98, 110);

`ifdef SPRITE_MIRROR_EN
        set_pos(100, 200, 1'b1, 1'b1);
        vblank_pulse();
        drive(100, 200, 1'b0, 1'b0);
        check("mirror_addr", 64'(pixel_addr), 64'd63);
        scan_row(200, 101, 170);
`endif

        // Randomized frames with sporadic blanking and input changes
        for (int f = 0; f < 14; f++) begin
            bx = (f % 4 == 3) ? int'($urandom_range(1000, 1100)) : int'($urandom_range(0, 1000));
            by = int'($urandom_range(0, 780));
            set_pos(bx, by, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
            vblank_pulse();
            hs = (bx > 1000) ? 980 : bx - 3;
            for (int r = 0; r < 5; r++) begin
                v = by - 2 + int'($urandom_range(0, H + 3));
                if (v > 767) v = 767;
                for (int h = hs; h <= hs + W + 5; h++) begin
                    if ($urandom_range(0, 31) == 0) xpos_i = 12'($urandom_range(0, 1100));
                    if (h >= 0 && h < SCREEN_W)
                        drive(h, v, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
